// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic ranging front end.
// Emits a trigger pulse, synchronises the sensor echo and measures its high
// time in prescaled ticks. Both the wait-for-echo and the echo-width phases
// have a hard timeout.
// Optional feature: define ECHO_RANGER_GLITCH_FILTER_EN to add a
// 3-sample glitch filter on the synchronised echo.
module echo_ranger #(
   parameter int CNT_LEN    = 16,
   parameter int TICK_DIV   = 50,
   parameter int TRIG_TICKS = 10,
   parameter int MAX_TICKS  = 30000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               echo,
   output logic               trig,
   output logic               busy,
   output logic               valid,
   output logic [CNT_LEN-1:0] distance,
   output logic               timed_out
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_LEN-1:0] TRIG_LAST  = CNT_LEN'(TRIG_TICKS - 1);
   localparam logic [CNT_LEN-1:0] MAX_LAST   = CNT_LEN'(MAX_TICKS - 1);
   localparam logic [CNT_LEN-1:0] MAX_CNT    = CNT_LEN'(MAX_TICKS);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

   state_t             state, state_nx;
   logic               echo_m, echo_r, echo_s, echo_d;
   logic               rise, fall, tick;
   logic [PW-1:0]      presc;
   logic [CNT_LEN-1:0] ticks;
   logic [CNT_LEN-1:0] dist_nx;
   logic               to_nx;

   // Two-flop synchroniser for the asynchronous echo pin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_m <= 1'b0;
         echo_r <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_r <= echo_m;
      end
   end

`ifdef ECHO_RANGER_GLITCH_FILTER_EN
   logic [1:0] echo_h;
   logic       echo_f;

   // Filtered level follows the synchronised echo only once the current
   // sample and the two before it agree; combinational on the current sample
   // so each edge gains exactly two cycles.
   always_comb begin
      echo_s = echo_f;
      if (echo_r && (&echo_h))
         echo_s = 1'b1;
      else if (!echo_r && !(|echo_h))
         echo_s = 1'b0;
   end

   // Sample history and held filtered level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_h <= '0;
         echo_f <= 1'b0;
      end else begin
         echo_h <= {echo_h[0], echo_r};
         echo_f <= echo_s;
      end
   end
`else
   assign echo_s = echo_r;
`endif

   // Delayed copy of the echo level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) echo_d <= 1'b0;
      else     echo_d <= echo_s;
   end

   assign rise = echo_s & ~echo_d;
   assign fall = ~echo_s & echo_d;
   assign tick = (presc == PRESC_LAST);

   // Prescaler and saturating tick counter, cleared on every state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         ticks <= '0;
      end else if (state_nx != state) begin
         presc <= '0;
         ticks <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick && ticks != MAX_CNT)
            ticks <= ticks + 1'b1;
      end
   end

   // State register plus registered outputs derived from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         trig      <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         distance  <= '0;
         timed_out <= 1'b0;
      end else begin
         state <= state_nx;
         trig  <= (state_nx == TRIG);
         busy  <= (state_nx != IDLE);
         valid <= (state_nx == DONE);
         if (state_nx == DONE) begin
            distance  <= dist_nx;
            timed_out <= to_nx;
         end
      end
   end

   // Next-state logic; a timeout fires on the tick that brings the count to MAX_TICKS
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = TRIG;
         TRIG:      if (tick && ticks == TRIG_LAST) state_nx = WAIT_RISE;
         WAIT_RISE: begin
            if (rise)
               state_nx = MEASURE;
            else if (tick && ticks == MAX_LAST)
               state_nx = DONE;
         end
         MEASURE:   if (fall || (tick && ticks == MAX_LAST)) state_nx = DONE;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Result values captured on entry to DONE; a fall wins over a coincident
   // timeout and includes the tick completing in the fall cycle
   always_comb begin
      dist_nx = distance;
      to_nx   = timed_out;
      case (state)
         WAIT_RISE: begin
            dist_nx = '0;
            to_nx   = 1'b1;
         end
         MEASURE: begin
            if (fall) begin
               dist_nx = ticks + CNT_LEN'(tick);
               to_nx   = 1'b0;
            end else begin
               dist_nx = MAX_CNT;
               to_nx   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_echo_ranger.sv
// Testbench for echo_ranger: directed and randomised measurements checked
// against a timing/arithmetic reference model of the ranging rules.
module tb_echo_ranger;

   localparam int CNT_LEN    = 8;
   localparam int TICK_DIV   = 4;
   localparam int TRIG_TICKS = 2;
   localparam int MAX_TICKS  = 100;
   localparam int TRIG_CYC   = TRIG_TICKS * TICK_DIV;
   localparam int TO_CYC     = MAX_TICKS * TICK_DIV;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               echo = 1'b0;
   logic               trig, busy, valid, timed_out;
   logic [CNT_LEN-1:0] distance;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int vcount = 0;
   int last_dist = 0;
   bit last_to = 1'b0;
   int last_vcyc = 0;

   echo_ranger #(
      .CNT_LEN   (CNT_LEN),
      .TICK_DIV  (TICK_DIV),
      .TRIG_TICKS(TRIG_TICKS),
      .MAX_TICKS (MAX_TICKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .echo     (echo),
      .trig     (trig),
      .busy     (busy),
      .valid    (valid),
      .distance (distance),
      .timed_out(timed_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every cycle in which valid is high
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         vcount++;
         last_dist = int'(distance);
         last_to   = timed_out;
         last_vcyc = cyc;
      end
   end

   // Reference: pin high for w cycles (w<0 means no echo) -> expected result
   function automatic void ref_result(input int w, output int d, output bit t);
      if (w < 0) begin
         d = 0; t = 1'b1;
      end else if (w > TO_CYC) begin
         d = MAX_TICKS; t = 1'b1;
      end else begin
         d = w / TICK_DIV; t = 1'b0;
      end
   endfunction

   task automatic launch(output int fall_cyc, output bit ok);
      int n;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      @(negedge clk);
      while (trig === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = (trig === 1'b0);
      fall_cyc = cyc;
   endtask

   task automatic wait_valid(input int v0, input int budget, output bit ok);
      int n;
      n = 0;
      while (vcount <= v0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      ok = (vcount > v0);
   endtask

   task automatic pulse_echo(input int d, input int w);
      repeat (d) @(posedge clk);
      #1 echo = 1'b1;
      repeat (w) @(posedge clk);
      #1 echo = 1'b0;
   endtask

   task automatic test_reset();
      int n, busy_low, v0, fc;
      bit ok;
      rst = 1'b1; start = 1'b0; echo = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({trig, busy, valid, distance, timed_out} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got trig=%b busy=%b valid=%b dist=%0d to=%b expected all 0",
                  trig, busy, valid, distance, timed_out);
      end
      v0 = vcount;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (trig !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_latency: got trig=%b busy=%b expected 1 1", trig, busy);
      end
      n = 0; busy_low = 0;
      while (trig === 1'b1 && n < 50) begin
         n++;
         if (busy !== 1'b1) busy_low++;
         @(negedge clk);
      end
      fc = cyc;
      checks++;
      if (n != TRIG_CYC) begin
         failures++;
         $display("FAIL trig_width: got %0d expected %0d", n, TRIG_CYC);
      end
      checks++;
      if (busy_low != 0) begin
         failures++;
         $display("FAIL busy_during_trig: got %0d low cycles expected 0", busy_low);
      end
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_vcyc - fc != TO_CYC) begin
         failures++;
         $display("FAIL reset_drain_timeout: got ok=%b latency=%0d expected 1 %0d",
                  ok, last_vcyc - fc, TO_CYC);
      end
   endtask

   task automatic test_no_echo();
      int v0, fc, ed;
      bit ok, et;
      v0 = vcount;
      ref_result(-1, ed, et);
      launch(fc, ok);
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL no_echo_valid: got none expected valid");
      end
      checks++;
      if (last_vcyc - fc != TO_CYC) begin
         failures++;
         $display("FAIL no_echo_latency: got %0d expected %0d", last_vcyc - fc, TO_CYC);
      end
      checks++;
      if (last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL no_echo_result: got %0d/%b expected %0d/%b", last_dist, last_to, ed, et);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL no_echo_after_done: got busy=%b valid=%b expected 0 0", busy, valid);
      end
   endtask

   task automatic test_normal();
      int widths[2] = '{40, 43};
      int v0, fc, ed;
      bit ok, et;
      foreach (widths[k]) begin
         v0 = vcount;
         ref_result(widths[k], ed, et);
         launch(fc, ok);
         pulse_echo(20, widths[k]);
         wait_valid(v0, TO_CYC + 50, ok);
         checks++;
         if (!ok || last_dist != ed || last_to != et) begin
            failures++;
            $display("FAIL normal_w%0d: got ok=%b %0d/%b expected %0d/%b",
                     widths[k], ok, last_dist, last_to, ed, et);
         end
         repeat (5) @(negedge clk);
         checks++;
         if (vcount != v0 + 1) begin
            failures++;
            $display("FAIL normal_valid_count_w%0d: got %0d expected 1", widths[k], vcount - v0);
         end
      end
   endtask

   task automatic test_random();
      int v0, fc, ed, d, w;
      bit ok, et;
      for (int i = 0; i < 8; i++) begin
         d = int'($urandom_range(1, 150));
         w = int'($urandom_range(1, 390));
         v0 = vcount;
         ref_result(w, ed, et);
         launch(fc, ok);
         pulse_echo(d, w);
         wait_valid(v0, TO_CYC + 50, ok);
         repeat (3) @(negedge clk);
         checks++;
         if (!ok || vcount != v0 + 1 || last_dist != ed || last_to != et) begin
            failures++;
            $display("FAIL random_%0d d=%0d w=%0d: got valids=%0d %0d/%b expected 1 %0d/%b",
                     i, d, w, vcount - v0, last_dist, last_to, ed, et);
         end
      end
   endtask

   task automatic test_stuck();
      int v0, fc, ed;
      bit ok, et;
      v0 = vcount;
      ref_result(500, ed, et);
      launch(fc, ok);
      repeat (10) @(posedge clk);
      #1 echo = 1'b1;
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL stuck_result: got ok=%b %0d/%b expected %0d/%b", ok, last_dist, last_to, ed, et);
      end
      v0 = vcount;
      ref_result(-1, ed, et);
      launch(fc, ok);
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_dist != ed || last_to != et || last_vcyc - fc != TO_CYC) begin
         failures++;
         $display("FAIL stuck_high_no_rise: got ok=%b %0d/%b lat=%0d expected %0d/%b lat=%0d",
                  ok, last_dist, last_to, last_vcyc - fc, ed, et, TO_CYC);
      end
      @(posedge clk); #1 echo = 1'b0;
      repeat (5) @(posedge clk);
      v0 = vcount;
      ref_result(40, ed, et);
      launch(fc, ok);
      pulse_echo(20, 40);
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL stuck_recover: got ok=%b %0d/%b expected %0d/%b", ok, last_dist, last_to, ed, et);
      end
   endtask

   task automatic test_busy_start();
      int v0, fc, ed;
      bit ok, et;
      v0 = vcount;
      ref_result(60, ed, et);
      launch(fc, ok);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      pulse_echo(20, 60);
      wait_valid(v0, TO_CYC + 50, ok);
      repeat (20) @(negedge clk);
      checks++;
      if (!ok || last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL busy_start_result: got ok=%b %0d/%b expected %0d/%b", ok, last_dist, last_to, ed, et);
      end
      checks++;
      if (vcount != v0 + 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_start_ignored: got valids=%0d busy=%b expected 1 0", vcount - v0, busy);
      end
   endtask

   task automatic test_reset_mid();
      int v0, fc, ed;
      bit ok, et;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (trig !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst_trig: got %b expected 1", trig);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (trig !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_rst_trig: got trig=%b busy=%b expected 0 0", trig, busy);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      launch(fc, ok);
      repeat (10) @(posedge clk);
      #1 echo = 1'b1;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({trig, busy, valid, distance, timed_out} !== '0) begin
         failures++;
         $display("FAIL rst_mid_measure: got trig=%b busy=%b valid=%b dist=%0d to=%b expected all 0",
                  trig, busy, valid, distance, timed_out);
      end
      echo = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      v0 = vcount;
      ref_result(40, ed, et);
      launch(fc, ok);
      pulse_echo(20, 40);
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL rst_then_measure: got ok=%b %0d/%b expected %0d/%b", ok, last_dist, last_to, ed, et);
      end
   endtask

`ifdef ECHO_RANGER_GLITCH_FILTER_EN
   task automatic test_glitch();
      int v0, fc, ed;
      bit ok, et;
      v0 = vcount;
      ref_result(40, ed, et);
      launch(fc, ok);
      pulse_echo(10, 2);
      pulse_echo(30, 40);
      wait_valid(v0, TO_CYC + 50, ok);
      checks++;
      if (!ok || last_dist != ed || last_to != et) begin
         failures++;
         $display("FAIL glitch_ignored: got ok=%b %0d/%b expected %0d/%b", ok, last_dist, last_to, ed, et);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_no_echo();
      test_normal();
      test_random();
      test_stuck();
      test_busy_start();
      test_reset_mid();
`ifdef ECHO_RANGER_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/echo_ranger.md
# echo_ranger

Ultrasonic ranging front end for UDAR. On `start` it emits a trigger pulse and synchronises the sensor echo. It then measures the echo high time in prescaled ticks, with a hard timeout on both the wait-for-echo and echo-width phases. It sits upstream of the range processing logic and produces one `distance` result, with a `valid` strobe, per measurement.

## Interface

Parameters:
- `CNT_LEN`, 16: width of the tick counter and of `distance`.
- `TICK_DIV`, 50: clk cycles per tick (≥2).
- `TRIG_TICKS`, 10: trigger pulse length in ticks (≥1).
- `MAX_TICKS`, 30000: timeout limit in ticks. Must satisfy 1 ≤ MAX_TICKS < 2^CNT_LEN.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request a measurement. Sampled only in IDLE.
- `echo`, input, 1: raw sensor echo, asynchronous to `clk`.
- `trig`, output, 1: registered sensor trigger.
- `busy`, output, 1: high in every state except IDLE.
- `valid`, output, 1: one-cycle result strobe.
- `distance`, output, CNT_LEN: echo width in ticks. Held until the next result.
- `timed_out`, output, 1: the last result hit MAX_TICKS. Held with `distance`.

## Operation

- **Echo synchroniser:** two flops produce `echo_s`; a third flop holds `echo_d`. A rise is `echo_s & ~echo_d`; a fall is `~echo_s & echo_d`.
- **Prescaler:** counts 0..TICK_DIV-1. A tick is asserted in the cycle the prescaler equals TICK_DIV-1, after which it wraps to 0. The prescaler and tick counter are cleared on every state entry.
- **Tick counter:** CNT_LEN bits, increments on each tick, and never exceeds MAX_TICKS.
- **FSM states:** IDLE, TRIG, WAIT_RISE, MEASURE, DONE.
  - **IDLE:** if `start` is high, go to TRIG.
  - **TRIG:** `trig` is 1. After TRIG_TICKS ticks, go to WAIT_RISE.
  - **WAIT_RISE:**
    - On an echo rise, go to MEASURE.
    - Else, if the tick counter reaches MAX_TICKS, go to DONE with `distance`=0 and `timed_out`=1.
    - An echo that is already high does not count as a rise.
  - **MEASURE:**
    - On an echo fall, go to DONE with `distance`=tick count and `timed_out`=0.
    - Else, if the counter reaches MAX_TICKS, go to DONE with `distance`=MAX_TICKS and `timed_out`=1.
    - Fall takes priority over timeout in the same cycle.
  - **DONE:** `valid`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored while `busy` is high; no queueing.
- **Reset:** every state goes to IDLE. All outputs become 0, the synchroniser flops become 0, and the counters are cleared.

## Timing

- **Reset values:** `trig`=0, `busy`=0, `valid`=0, `distance`=0, `timed_out`=0.
- **Start:** `start` high at edge N gives `trig`=1 and `busy`=1 from cycle N+1.
- **Trigger pulse:** `trig` is high for exactly TRIG_TICKS×TICK_DIV cycles.
- **Echo latency:** an echo transition is recognised 2–3 clk cycles after the pin changes. Without the filter, this adds 0 cycles of width error; rise and fall have equal latency.
- **Resolution:** `distance` counts completed ticks, so remainder cycles are truncated.
- **Result:** `distance` and `timed_out` update at the edge entering DONE. `valid` is high in that same cycle. `busy` drops on the following cycle, and `start` is accepted from that cycle.
- **WAIT_RISE timeout:** fires MAX_TICKS×TICK_DIV cycles after entry.
- **Async reset:** asserting `rst` forces `trig` low without waiting for a clock.

## Configuration

- Macro `ECHO_RANGER_GLITCH_FILTER_EN`.
- **Defined:** `echo_s` is replaced by a filtered level. The level changes only after the synchronised echo holds a new value for 3 consecutive cycles. Pulses shorter than 3 cycles are ignored, and both edges gain 2 extra cycles of latency.
- **Undefined:** the raw 2-flop synchronised level is used, and no filtering is applied.

## Test plan

Bench parameters: CNT_LEN=8, TICK_DIV=4, TRIG_TICKS=2, MAX_TICKS=100.

- **Reset:** apply reset, then idle 10 cycles -> all outputs 0. A `start` pulse leads to `trig` high for exactly 8 cycles, beginning one cycle after `start`, with `busy` high throughout.
- **Normal echo:** drive echo high for 40 cycles, 20 cycles after `trig` falls -> one `valid` pulse, `distance`=10, `timed_out`=0.
- **Echo width with remainder:** drive echo high for 43 cycles -> `distance`=10.
- **No echo:** echo never rises -> `valid` 400 cycles after entering WAIT_RISE, with `distance`=0 and `timed_out`=1.
- **Stuck echo:** echo stuck high 500 cycles -> `distance`=100, `timed_out`=1. A second `start` while echo is still high produces no MEASURE until echo falls and rises again.
- **Reset and start rules:**
  - Assert `rst` mid-MEASURE -> all outputs 0 immediately, and a subsequent `start` measures normally.
  - A `start` while busy -> ignored, with exactly one `valid`.
  - With the macro defined, a 2-cycle echo glitch is ignored.
